// File: rtl/add_serial_param.sv
// add_serial_param: digit-serial adder/subtractor. Masks operands at load, waits DELAY_CYCLES,
// then consumes DIGIT bits per cycle LSB-first. The result is held until the next accepted start.
`default_nettype none

module add_serial_param #(
  parameter int               WIDTH        = 8,
  parameter int               DIGIT        = 1,
  parameter int               DELAY_CYCLES = 1,
  parameter logic [WIDTH-1:0] A_MASK       = '0,
  parameter logic [WIDTH-1:0] B_MASK       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int N_DIG   = WIDTH / DIGIT;
  localparam int CNT_MAX = (N_DIG > DELAY_CYCLES) ? N_DIG : DELAY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(N_DIG - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_ADD   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] out_shift;

  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign sum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

  // New digit enters at the top so the LSB digit lands at bit 0 after N_DIG shifts.
  generate
    if (DIGIT == WIDTH) begin : g_full_digit
      assign out_shift = sum[DIGIT-1:0];
    end else begin : g_part_digit
      assign out_shift = {sum[DIGIT-1:0], out_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (DELAY_CYCLES > 0) ? S_DELAY : S_ADD;
      S_DELAY:        if (cnt_q == DLY_LAST) state_d = S_ADD;
      S_ADD:          if (cnt_q == ADD_LAST) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_DELAY) || (state_q == S_ADD);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = a ^ A_MASK;
      b_d     = sub ? ~(b ^ B_MASK) : (b ^ B_MASK);
      carry_d = sub;
      cnt_d   = '0;
      out_d   = '0;
      cout_d  = 1'b0;
    end else if (state_q == S_DELAY) begin
      cnt_d = (cnt_q == DLY_LAST) ? '0 : cnt_q + 1'b1;
    end else if (state_q == S_ADD) begin
      out_d   = out_shift;
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = sum[DIGIT];
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == ADD_LAST) cout_d = sum[DIGIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  assign out       = out_q;
  assign carry_out = cout_q;

endmodule

`default_nettype wire
